kf6845_address_generator: RTL and testbench

Vertical/raster scan counter stage of the KF6845 CRTC. Driven by the horizontal timing stage's end-of-line strobe, it generates the refresh memory address MA, the raster address RA, the frame-end strobe V_total, vertical display enable and vertical sync. These outputs feed the cursor control stage directly (MA/RA compare, V_total blink counting) and the external video pins.

---
 rtl/kf6845_address_generator.sv | 226 ++++++++++++++++++++++
 tb/tb_kf6845_address_generator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf6845_address_generator.sv
// KF6845 CRTC vertical/raster scan stage.
// Generates MA/RA, the frame-end strobe, vertical display enable and VSYNC.
module kf6845_address_generator (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        video_clock_enable,
    input  logic [7:0]  internal_data_bus_in,
    input  logic        write_vertical_total_register,
    input  logic        write_vertical_total_adjust_register,
    input  logic        write_vertical_displayed_register,
    input  logic        write_vertical_sync_position_register,
    input  logic        write_max_scan_line_register,
    input  logic        write_start_address_h_register,
    input  logic        write_start_address_l_register,
    input  logic [7:0]  horizontal_displayed,
    input  logic        H_end,
    output logic [13:0] MA,
    output logic [4:0]  RA,
    output logic        V_total,
    output logic        V_display,
    output logic        VSYNC
);

    typedef enum logic {
        ROWS   = 1'b0,
        ADJUST = 1'b1
    } state_t;

    logic [6:0]  vertical_total_q;
    logic [6:0]  vertical_total_d;
    logic [4:0]  total_adjust_q;
    logic [4:0]  total_adjust_d;
    logic [6:0]  vertical_displayed_q;
    logic [6:0]  vertical_displayed_d;
    logic [6:0]  vsync_position_q;
    logic [6:0]  vsync_position_d;
    logic [4:0]  max_scan_line_q;
    logic [4:0]  max_scan_line_d;
    logic [13:0] start_address_q;
    logic [13:0] start_address_d;

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  row_q;
    logic [6:0]  row_d;
    logic [4:0]  ra_q;
    logic [4:0]  ra_d;
    logic [4:0]  adjust_count_q;
    logic [4:0]  adjust_count_d;
    logic [13:0] row_start_q;
    logic [13:0] row_start_d;
    logic [13:0] ma_q;
    logic [13:0] ma_d;
    logic [3:0]  vsync_count_q;
    logic [3:0]  vsync_count_d;
    logic        vsync_q;
    logic        vsync_d;
    logic        v_total_q;
    logic        v_total_d;
    logic        v_display_q;
    logic        v_display_d;

    logic        line_end;
    logic        frame_end;
    logic        row_entry;
    logic        ra_at_max;
    logic        row_at_total;
    logic        adjust_done;
    logic [13:0] next_row_start;

    assign line_end       = video_clock_enable & H_end;
    assign ra_at_max      = (ra_q == max_scan_line_q);
    assign row_at_total   = (row_q == vertical_total_q);
    assign adjust_done    = (adjust_count_q == total_adjust_q);
    assign next_row_start = row_start_q + {6'd0, horizontal_displayed};

    // Register file: writes are independent of the character clock.
    always_comb begin
        vertical_total_d     = vertical_total_q;
        total_adjust_d       = total_adjust_q;
        vertical_displayed_d = vertical_displayed_q;
        vsync_position_d     = vsync_position_q;
        max_scan_line_d      = max_scan_line_q;
        start_address_d      = start_address_q;
        if (write_vertical_total_register)
            vertical_total_d = internal_data_bus_in[6:0];
        if (write_vertical_total_adjust_register)
            total_adjust_d = internal_data_bus_in[4:0];
        if (write_vertical_displayed_register)
            vertical_displayed_d = internal_data_bus_in[6:0];
        if (write_vertical_sync_position_register)
            vsync_position_d = internal_data_bus_in[6:0];
        if (write_max_scan_line_register)
            max_scan_line_d = internal_data_bus_in[4:0];
        if (write_start_address_h_register)
            start_address_d[13:8] = internal_data_bus_in[5:0];
        if (write_start_address_l_register)
            start_address_d[7:0] = internal_data_bus_in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vertical_total_q     <= 7'd0;
            total_adjust_q       <= 5'd0;
            vertical_displayed_q <= 7'd0;
            vsync_position_q     <= 7'd0;
            max_scan_line_q      <= 5'd0;
            start_address_q      <= 14'd0;
        end else begin
            vertical_total_q     <= vertical_total_d;
            total_adjust_q       <= total_adjust_d;
            vertical_displayed_q <= vertical_displayed_d;
            vsync_position_q     <= vsync_position_d;
            max_scan_line_q      <= max_scan_line_d;
            start_address_q      <= start_address_d;
        end
    end

    // Scan counters and row/adjust state machine.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        ra_d           = ra_q;
        adjust_count_d = adjust_count_q;
        row_start_d    = row_start_q;
        ma_d           = ma_q;
        frame_end      = 1'b0;
        row_entry      = 1'b0;
        if (video_clock_enable) begin
            if (!H_end) begin
                ma_d = ma_q + 14'd1;
            end else begin
                unique case (state_q)
                    ROWS: begin
                        if (!ra_at_max) begin
                            ra_d = ra_q + 5'd1;
                            ma_d = row_start_q;
                        end else if (!row_at_total) begin
                            ra_d        = 5'd0;
                            row_d       = row_q + 7'd1;
                            row_start_d = next_row_start;
                            ma_d        = next_row_start;
                            row_entry   = 1'b1;
                        end else if (total_adjust_q != 5'd0) begin
                            state_d        = ADJUST;
                            adjust_count_d = 5'd1;
                            ra_d           = 5'd0;
                            ma_d           = row_start_q;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                    ADJUST: begin
                        if (!adjust_done) begin
                            adjust_count_d = adjust_count_q + 5'd1;
                            ra_d           = ra_q + 5'd1;
                            ma_d           = row_start_q;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                endcase
                if (frame_end) begin
                    state_d        = ROWS;
                    row_d          = 7'd0;
                    ra_d           = 5'd0;
                    adjust_count_d = 5'd0;
                    row_start_d    = start_address_q;
                    ma_d           = start_address_q;
                    row_entry      = 1'b1;
                end
            end
        end
        v_total_d   = frame_end;
        v_display_d = (state_d == ROWS) && (row_d < vertical_displayed_q);
    end

    // Sync runs for 16 line ends once started and cannot be retriggered.
    always_comb begin
        vsync_d       = vsync_q;
        vsync_count_d = vsync_count_q;
        if (line_end) begin
            if (vsync_q) begin
                vsync_count_d = vsync_count_q + 4'd1;
                if (vsync_count_q == 4'hf)
                    vsync_d = 1'b0;
            end else if (row_entry && (row_d == vsync_position_q)) begin
                vsync_d       = 1'b1;
                vsync_count_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ROWS;
            row_q          <= 7'd0;
            ra_q           <= 5'd0;
            adjust_count_q <= 5'd0;
            row_start_q    <= 14'd0;
            ma_q           <= 14'd0;
            vsync_count_q  <= 4'd0;
            vsync_q        <= 1'b0;
            v_total_q      <= 1'b0;
            v_display_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            ra_q           <= ra_d;
            adjust_count_q <= adjust_count_d;
            row_start_q    <= row_start_d;
            ma_q           <= ma_d;
            vsync_count_q  <= vsync_count_d;
            vsync_q        <= vsync_d;
            v_total_q      <= v_total_d;
            v_display_q    <= v_display_d;
        end
    end

    assign MA        = ma_q;
    assign RA        = ra_q;
    assign V_total   = v_total_q;
    assign V_display = v_display_q;
    assign VSYNC     = vsync_q;

endmodule

// File: tb/tb_kf6845_address_generator.sv
// Randomized scoreboard bench for the KF6845 vertical address generator.
// A line-level reference model predicts every clock's outputs.
module tb_kf6845_address_generator;

    logic        clock = 1'b1;
    logic        reset_n = 1'b0;
    logic        video_clock_enable = 1'b0;
    logic [7:0]  internal_data_bus_in = 8'd0;
    logic        write_vertical_total_register = 1'b0;
    logic        write_vertical_total_adjust_register = 1'b0;
    logic        write_vertical_displayed_register = 1'b0;
    logic        write_vertical_sync_position_register = 1'b0;
    logic        write_max_scan_line_register = 1'b0;
    logic        write_start_address_h_register = 1'b0;
    logic        write_start_address_l_register = 1'b0;
    logic [7:0]  horizontal_displayed = 8'd0;
    logic        H_end = 1'b0;
    logic [13:0] MA;
    logic [4:0]  RA;
    logic        V_total;
    logic        V_display;
    logic        VSYNC;

    kf6845_address_generator dut (
        .clock(clock),
        .reset_n(reset_n),
        .video_clock_enable(video_clock_enable),
        .internal_data_bus_in(internal_data_bus_in),
        .write_vertical_total_register(write_vertical_total_register),
        .write_vertical_total_adjust_register(write_vertical_total_adjust_register),
        .write_vertical_displayed_register(write_vertical_displayed_register),
        .write_vertical_sync_position_register(write_vertical_sync_position_register),
        .write_max_scan_line_register(write_max_scan_line_register),
        .write_start_address_h_register(write_start_address_h_register),
        .write_start_address_l_register(write_start_address_l_register),
        .horizontal_displayed(horizontal_displayed),
        .H_end(H_end),
        .MA(MA),
        .RA(RA),
        .V_total(V_total),
        .V_display(V_display),
        .VSYNC(VSYNC)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [13:0] ma;
        logic [4:0]  ra;
        logic        vt;
        logic        vd;
        logic        vs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hd_next = 0;

    // Reference model state (plain integers).
    int r_vt, r_adj, r_vd, r_vsp, r_msl, r_start;
    int m_row, m_ra, m_adj, m_row_start, m_ma, m_vs_left;
    bit m_in_adjust, m_vs, m_vt, m_vd;

    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        r_vt = 0; r_adj = 0; r_vd = 0; r_vsp = 0; r_msl = 0; r_start = 0;
        m_row = 0; m_ra = 0; m_adj = 0; m_row_start = 0; m_ma = 0;
        m_vs_left = 0; m_in_adjust = 0; m_vs = 0; m_vt = 0; m_vd = 0;
    endtask

    task automatic model_step(input bit ce, input bit he, input int wm,
                              input int data, input int hd);
        bit fe;
        bit entered;
        fe = 0;
        entered = 0;
        if (ce && !he) begin
            m_ma = (m_ma + 1) % 16384;
        end else if (ce && he) begin
            if (!m_in_adjust) begin
                if (m_ra != r_msl) begin
                    m_ra = (m_ra + 1) % 32;
                    m_ma = m_row_start;
                end else if (m_row != r_vt) begin
                    m_ra = 0;
                    m_row = (m_row + 1) % 128;
                    m_row_start = (m_row_start + hd) % 16384;
                    m_ma = m_row_start;
                    entered = 1;
                end else if (r_adj != 0) begin
                    m_in_adjust = 1;
                    m_adj = 1;
                    m_ra = 0;
                    m_ma = m_row_start;
                end else begin
                    fe = 1;
                end
            end else begin
                if (m_adj != r_adj) begin
                    m_adj = (m_adj + 1) % 32;
                    m_ra = (m_ra + 1) % 32;
                    m_ma = m_row_start;
                end else begin
                    fe = 1;
                end
            end
            if (fe) begin
                m_in_adjust = 0;
                m_row = 0;
                m_ra = 0;
                m_adj = 0;
                m_row_start = r_start;
                m_ma = r_start;
                entered = 1;
            end
            if (m_vs) begin
                m_vs_left--;
                if (m_vs_left == 0) m_vs = 0;
            end else if (entered && m_row == r_vsp) begin
                m_vs = 1;
                m_vs_left = 16;
            end
        end
        m_vt = fe;
        m_vd = !m_in_adjust && (m_row < r_vd);
        if (wm[0]) r_vt = data % 128;
        if (wm[1]) r_adj = data % 32;
        if (wm[2]) r_vd = data % 128;
        if (wm[3]) r_vsp = data % 128;
        if (wm[4]) r_msl = data % 32;
        if (wm[5]) r_start = ((data % 64) << 8) | (r_start % 256);
        if (wm[6]) r_start = (r_start & 16'h3F00) | (data % 256);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ma = m_ma[13:0];
        e.ra = m_ra[4:0];
        e.vt = m_vt;
        e.vd = m_vd;
        e.vs = m_vs;
        return e;
    endfunction

    // One clock of stimulus; expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit rn, input bit ce, input bit he,
                       input int wm, input int data);
        @(negedge clock);
        reset_n = rn;
        video_clock_enable = ce;
        H_end = he;
        internal_data_bus_in = data[7:0];
        horizontal_displayed = hd_next[7:0];
        write_vertical_total_register = wm[0];
        write_vertical_total_adjust_register = wm[1];
        write_vertical_displayed_register = wm[2];
        write_vertical_sync_position_register = wm[3];
        write_max_scan_line_register = wm[4];
        write_start_address_h_register = wm[5];
        write_start_address_l_register = wm[6];
        if (!rn) model_reset();
        else model_step(ce, he, wm, data, hd_next);
        exp_q.push_back(model_out());
    endtask

    task automatic wr(input int wm, input int data);
        cyc(1, 0, 0, wm, data);
    endtask

    task automatic run_lines(input int n, input int len);
        for (int l = 0; l < n; l++) begin
            for (int t = 0; t < len - 1; t++) cyc(1, 1, 0, 0, 0);
            cyc(1, 1, 1, 0, 0);
        end
    endtask

    task automatic reset_mid();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_MA", int'(MA), 0);
        check("async_RA", int'(RA), 0);
        check("async_V_total", int'(V_total), 0);
        check("async_V_display", int'(V_display), 0);
        check("async_VSYNC", int'(VSYNC), 0);
        model_reset();
        exp_q.push_back(model_out());
        repeat (2) cyc(0, 1, 1, 0, 0);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("MA", int'(MA), int'(e.ma));
            check("RA", int'(RA), int'(e.ra));
            check("V_total", int'(V_total), int'(e.vt));
            check("V_display", int'(V_display), int'(e.vd));
            check("VSYNC", int'(VSYNC), int'(e.vs));
        end
    end

    initial begin
        int k;
        int d;
        model_reset();
        repeat (3) cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);

        hd_next = 4;
        wr(32'h10, 3);
        wr(32'h01, 1);
        wr(32'h02, 0);
        wr(32'h04, 2);
        wr(32'h20, 8'h01);
        wr(32'h40, 8'h00);
        run_lines(24, 4);

        wr(32'h02, 2);
        run_lines(30, 4);

        wr(32'h02, 0);
        wr(32'h08, 1);
        wr(32'h10, 7);
        wr(32'h01, 3);
        run_lines(68, 4);

        wr(32'h10, 3);
        wr(32'h01, 1);
        wr(32'h08, 8'h7F);
        run_lines(3, 4);
        cyc(1, 1, 0, 32'h20, 8'h3F);
        cyc(1, 1, 0, 32'h40, 8'hFE);
        run_lines(18, 4);

        repeat (10) cyc(1, 0, 1, 0, 0);
        run_lines(2, 4);

        run_lines(5, 4);
        reset_mid();
        cyc(1, 1, 1, 0, 0);
        run_lines(4, 3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) hd_next = $urandom_range(0, 255);
            k = -1;
            d = 0;
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(0, 6);
                case (k)
                    0: d = $urandom_range(0, 6) | ($urandom_range(0, 1) << 7);
                    1: d = $urandom_range(0, 3) | ($urandom_range(0, 7) << 5);
                    2: d = $urandom_range(0, 7) | ($urandom_range(0, 1) << 7);
                    3: d = $urandom_range(0, 7) | ($urandom_range(0, 1) << 7);
                    4: d = $urandom_range(0, 3) | ($urandom_range(0, 7) << 5);
                    default: d = $urandom_range(0, 255);
                endcase
            end
            cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                (k < 0) ? 0 : (1 << k), d);
        end

        @(posedge clock);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
